regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: the ALU result path and the load/memory result path. Accepts at most one write per cycle through a valid/ready handshake, registers the winner, and drives the register file's `reg_write`, `rd` and `write_rd` inputs one cycle later. Writes to `$0` are accepted and discarded, so `$0` always reads as zero. Sits between the execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_arb2.sv | 67 ++++++
 rtl/regfile_write_arbiter.sv | 86 ++++++++
 tb/tb_regfile_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-index constants and writeback source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int                   REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_t;

endpackage

`default_nettype wire

// File: rtl/wb_arb2.sv
// ============================================================================
// Module      : wb_arb2
// Description : Two-way writeback arbiter (ALU vs memory) with one-hot grants.
//               Fixed priority with starvation override by default; round-robin
//               when REGFILE_ARB_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arb2
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_alu,
    input  logic i_req_mem,
    output logic o_gnt_alu,
    output logic o_gnt_mem
);

    logic w_alu_wins;

`ifdef REGFILE_ARB_RR_EN
    wb_src_t r_pref;

    always_comb begin
        w_alu_wins = i_req_alu && (!i_req_mem || (r_pref == WB_ALU));
        o_gnt_alu  = rst_n && w_alu_wins;
        o_gnt_mem  = rst_n && i_req_mem && !w_alu_wins;
    end

    // Every grant hands preference to the requester that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pref <= WB_ALU;
        end else if (o_gnt_alu) begin
            r_pref <= WB_MEM;
        end else if (o_gnt_mem) begin
            r_pref <= WB_ALU;
        end
    end
`else
    logic [3:0] r_starve;

    always_comb begin
        w_alu_wins = i_req_alu && (!i_req_mem || (r_starve == 4'(STARVE_LIMIT)));
        o_gnt_alu  = rst_n && w_alu_wins;
        o_gnt_mem  = rst_n && i_req_mem && !w_alu_wins;
    end

    // Saturation is implicit: at the limit the ALU wins and the count clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
        end else if (!i_req_alu || o_gnt_alu) begin
            r_starve <= 4'd0;
        end else if (o_gnt_mem) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register-file write port between ALU and memory
//               writeback; registers the winner and drives the write one cycle
//               later. Optional macro: REGFILE_ARB_RR_EN (round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [REG_IDX_W-1:0] i_alu_rd,
    input  logic [DATA_W-1:0]    i_alu_data,
    input  logic                 i_mem_valid,
    output logic                 o_mem_ready,
    input  logic [REG_IDX_W-1:0] i_mem_rd,
    input  logic [DATA_W-1:0]    i_mem_data,
    output logic                 o_reg_write,
    output logic [REG_IDX_W-1:0] o_rd,
    output logic [DATA_W-1:0]    o_write_rd,
    output logic                 o_grant_src
);

    logic                 w_gnt_alu;
    logic                 w_gnt_mem;
    logic                 w_xfer;
    logic [REG_IDX_W-1:0] w_rd;
    logic [DATA_W-1:0]    w_data;

    logic                 r_reg_write;
    logic [REG_IDX_W-1:0] r_rd;
    logic [DATA_W-1:0]    r_data;
    wb_src_t              r_src;

    wb_arb2 #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req_alu (i_alu_valid),
        .i_req_mem (i_mem_valid),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_mem (w_gnt_mem)
    );

    // The output stage drains every cycle, so a grant is always an acceptance.
    always_comb begin
        o_alu_ready = w_gnt_alu;
        o_mem_ready = w_gnt_mem;
        w_xfer      = w_gnt_alu || w_gnt_mem;
        w_rd        = w_gnt_mem ? i_mem_rd   : i_alu_rd;
        w_data      = w_gnt_mem ? i_mem_data : i_alu_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write <= 1'b0;
            r_rd        <= REG_ZERO;
            r_data      <= '0;
            r_src       <= WB_ALU;
        end else begin
            r_reg_write <= w_xfer && (w_rd != REG_ZERO);
            if (w_xfer) begin
                r_rd   <= w_rd;
                r_data <= w_data;
                r_src  <= w_gnt_mem ? WB_MEM : WB_ALU;
            end
        end
    end

    assign o_reg_write = r_reg_write;
    assign o_rd        = r_rd;
    assign o_write_rd  = r_data;
    assign o_grant_src = r_src;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Randomized self-checking bench against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid;
    logic [4:0]    alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          reg_write;
    logic [4:0]    rd;
    logic [DW-1:0] write_rd;
    logic          grant_src;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int            m_starve;
    bit            m_pref_mem;
    bit            e_we;
    logic [4:0]    e_rd;
    logic [DW-1:0] e_data;
    bit            e_src;
    logic [DW-1:0] rf_m [32];
    logic [DW-1:0] rf_d [32];

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .STARVE_LIMIT (SL),
        .DATA_W       (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_alu_valid (alu_valid),
        .o_alu_ready (alu_ready),
        .i_alu_rd    (alu_rd),
        .i_alu_data  (alu_data),
        .i_mem_valid (mem_valid),
        .o_mem_ready (mem_ready),
        .i_mem_rd    (mem_rd),
        .i_mem_data  (mem_data),
        .o_reg_write (reg_write),
        .o_rd        (rd),
        .o_write_rd  (write_rd),
        .o_grant_src (grant_src)
    );

    function automatic void model_reset();
        m_starve   = 0;
        m_pref_mem = 1'b0;
        e_we       = 1'b0;
        e_rd       = 5'd0;
        e_data     = '0;
        e_src      = 1'b0;
    endfunction

    // Returns 0 = nobody, 1 = ALU, 2 = memory; advances the arbitration model.
    function automatic int model_pick(bit av, bit mv);
        int w;
        w = 0;
`ifdef REGFILE_ARB_RR_EN
        if (av && mv)  w = m_pref_mem ? 2 : 1;
        else if (av)   w = 1;
        else if (mv)   w = 2;
        if (w == 1)      m_pref_mem = 1'b1;
        else if (w == 2) m_pref_mem = 1'b0;
`else
        if (av && mv)  w = (m_starve >= SL) ? 1 : 2;
        else if (av)   w = 1;
        else if (mv)   w = 2;
        if (!av || w == 1) m_starve = 0;
        else               m_starve = m_starve + 1;
`endif
        return w;
    endfunction

    task automatic do_cycle(input bit av, input logic [4:0] ard, input logic [DW-1:0] ad,
                            input bit mv, input logic [4:0] mrd, input logic [DW-1:0] md,
                            output int w, output bit oa, output bit om);
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        w  = model_pick(av, mv);
        oa = alu_ready;
        om = mem_ready;
        checks++;
        if (alu_ready !== (w == 1) || mem_ready !== (w == 2)) begin
            errors++;
            $display("FAIL ready: alu=%b mem=%b expected alu=%b mem=%b",
                     alu_ready, mem_ready, (w == 1), (w == 2));
        end
        @(posedge clk);
        #1;
        if (w != 0) begin
            e_rd   = (w == 1) ? ard : mrd;
            e_data = (w == 1) ? ad  : md;
            e_src  = (w == 2);
            e_we   = (e_rd != 5'd0);
        end else begin
            e_we = 1'b0;
        end
        checks++;
        if (reg_write !== e_we || rd !== e_rd || write_rd !== e_data || grant_src !== e_src) begin
            errors++;
            $display("FAIL outstage: we=%b rd=%0d data=%h src=%b expected we=%b rd=%0d data=%h src=%b",
                     reg_write, rd, write_rd, grant_src, e_we, e_rd, e_data, e_src);
        end
        if (e_we) rf_m[e_rd] = e_data;
        if (reg_write === 1'b1) rf_d[rd] = write_rd;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = 5'd0; mem_rd = 5'd0; alu_data = '0; mem_data = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        int w; bit oa, om;
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (reg_write !== 1'b0 || rd !== 5'd0 || write_rd !== '0 || grant_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b rd=%0d data=%h src=%b expected all zero",
                     reg_write, rd, write_rd, grant_src);
        end
        checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: alu=%b mem=%b expected 0 0", alu_ready, mem_ready);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        do_cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, w, oa, om);
        checks++;
`ifdef REGFILE_ARB_RR_EN
        if (oa !== 1'b1 || om !== 1'b0) begin
            errors++;
            $display("FAIL first_grant: alu=%b mem=%b expected alu=1 mem=0", oa, om);
        end
`else
        if (oa !== 1'b0 || om !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: alu=%b mem=%b expected alu=0 mem=1", oa, om);
        end
`endif
        // ALU still has its write pending
        do_cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0, w, oa, om);
    endtask

    task automatic test_alu_only();
        int w; bit oa, om;
        do_cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0, w, oa, om);
        checks++;
        if (oa !== 1'b1 || reg_write !== 1'b1 || rd !== 5'd5 || write_rd !== 32'h1234 || grant_src !== 1'b0) begin
            errors++;
            $display("FAIL alu_only: ready=%b we=%b rd=%0d data=%h src=%b expected 1 1 5 00001234 0",
                     oa, reg_write, rd, write_rd, grant_src);
        end
    endtask

    task automatic test_zero_drop();
        int w; bit oa, om;
        do_cycle(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, w, oa, om);
        checks++;
        if (om !== 1'b1 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL zero_drop: ready=%b we=%b expected ready=1 we=0", om, reg_write);
        end
    endtask

    task automatic test_arbitration();
        int w; bit oa, om;
        bit exp_alu [6];
`ifdef REGFILE_ARB_RR_EN
        exp_alu = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_alu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            do_cycle(1'b1, 5'd10, DW'(32'hA00 + k), 1'b1, 5'd11, DW'(32'hB00 + k), w, oa, om);
            checks++;
            if (oa !== exp_alu[k] || om !== !exp_alu[k]) begin
                errors++;
                $display("FAIL arb_seq[%0d]: alu=%b mem=%b expected alu=%b mem=%b",
                         k, oa, om, exp_alu[k], !exp_alu[k]);
            end
        end
    endtask

    task automatic test_same_rd();
        int w; bit oa, om;
        do_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, w, oa, om);
        do_cycle(1'b1, 5'd8, 32'd1, 1'b1, 5'd8, 32'd2, w, oa, om);
`ifndef REGFILE_ARB_RR_EN
        checks++;
        if (write_rd !== 32'd2 || rd !== 5'd8) begin
            errors++;
            $display("FAIL same_rd_first: rd=%0d data=%0d expected rd=8 data=2", rd, write_rd);
        end
`endif
        if (w == 2) do_cycle(1'b1, 5'd8, 32'd1, 1'b0, 5'd0, '0, w, oa, om);
        else        do_cycle(1'b0, 5'd0, '0, 1'b1, 5'd8, 32'd2, w, oa, om);
        checks++;
        if (rf_d[8] !== rf_m[8]) begin
            errors++;
            $display("FAIL same_rd_final: r8=%0d expected %0d", rf_d[8], rf_m[8]);
        end
`ifndef REGFILE_ARB_RR_EN
        checks++;
        if (rf_d[8] !== 32'd1) begin
            errors++;
            $display("FAIL same_rd_value: r8=%0d expected 1", rf_d[8]);
        end
`endif
    endtask

    task automatic test_random();
        int w; bit oa, om;
        bit pa = 1'b0, pm = 1'b0;
        logic [4:0] ard = 5'd0, mrd = 5'd0;
        logic [DW-1:0] ad = '0, md = '0;
        for (int n = 0; n < 300; n++) begin
            if (!pa && $urandom_range(0, 9) < 7) begin
                pa = 1'b1; ard = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!pm && $urandom_range(0, 9) < 7) begin
                pm = 1'b1; mrd = 5'($urandom_range(0, 31)); md = $urandom;
            end
            do_cycle(pa, ard, ad, pm, mrd, md, w, oa, om);
            if (w == 1) pa = 1'b0;
            if (w == 2) pm = 1'b0;
        end
        do_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, w, oa, om);
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (rf_d[r] !== rf_m[r]) begin
                errors++;
                $display("FAIL rf[%0d]: got %h expected %h", r, rf_d[r], rf_m[r]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int w; bit oa, om;
        do_cycle(1'b1, 5'd7, 32'hCAFE, 1'b1, 5'd9, 32'hBEEF, w, oa, om);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (reg_write !== 1'b0 || rd !== 5'd0 || write_rd !== '0 || grant_src !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: we=%b rd=%0d data=%h src=%b expected all zero",
                     reg_write, rd, write_rd, grant_src);
        end
        checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_ready: alu=%b mem=%b expected 0 0", alu_ready, mem_ready);
        end
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        do_cycle(1'b1, 5'd7, 32'hCAFE, 1'b0, 5'd0, '0, w, oa, om);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            rf_m[r] = '0;
            rf_d[r] = '0;
        end
        model_reset();
        idle_inputs();
        test_reset();
        test_alu_only();
        test_zero_drop();
        test_arbitration();
        test_same_rd();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
